// File: rtl/uart_led_cmd_ctrl.sv
// uart_led_cmd_ctrl
//   Command parser between a simpleuart-style register port and N_CH LED PWM
//   channels. Single digits set an on/off colour mask, "L<c><hh>" sets the
//   brightness of channel c. Every command is answered with ACK_CHAR or
//   NAK_CHAR. Brightness updates are copied into the PWM only when the
//   PWM counter wraps to 0, so no period is ever cut short.
//
// Ports
//   hw_clk, resetn   clock, synchronous active-low reset
//   reg_dat_we/di    transmit strobe and byte (di[31:8] always 0)
//   reg_dat_wait     transmitter busy; write accepted when we=1 and wait=0
//   reg_dat_re/do    receive pop strobe and data (do[8]=1 means empty)
//   pwm_out          per-channel PWM output
//   busy             high whenever the parser is not idle
//   err_pulse        one-cycle pulse when a NAK reply starts
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | waiting for the first byte of a command
// ST_GET_CH | 'L' seen, waiting for the channel digit
// ST_GET_HI | waiting for the high hex nibble of the level
// ST_GET_LO | waiting for the low hex nibble of the level
// ST_REPLY  | holding the ACK/NAK byte on di until accepted
module uart_led_cmd_ctrl #(
    parameter int unsigned     N_CH        = 3,
    parameter int unsigned     PWM_BITS    = 8,
    parameter int unsigned     PRESCALE    = 1,
    parameter int unsigned     TIMEOUT_CYC = 120000,
    parameter logic [N_CH-1:0] RESET_MASK  = 3'b010,
    parameter logic [7:0]      ACK_CHAR    = "K",
    parameter logic [7:0]      NAK_CHAR    = "?"
) (
    input  logic            hw_clk,
    input  logic            resetn,
    output logic            reg_dat_we,
    output logic            reg_dat_re,
    output logic [31:0]     reg_dat_di,
    input  logic [31:0]     reg_dat_do,
    input  logic            reg_dat_wait,
    output logic [N_CH-1:0] pwm_out,
    output logic            busy,
    output logic            err_pulse
);

    localparam int unsigned       CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned       TO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]        PRE_LOAD = 8'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CH,
        ST_GET_HI,
        ST_GET_LO,
        ST_REPLY
    } state_t;

    state_t                          state_q, state_d;
    logic [N_CH-1:0][PWM_BITS-1:0]   shadow_q, shadow_d;
    logic [N_CH-1:0][PWM_BITS-1:0]   active_q;
    logic [CH_W-1:0]                 ch_q, ch_d;
    logic [3:0]                      hi_q, hi_d;
    logic [7:0]                      reply_q, reply_d;
    logic [TO_W-1:0]                 to_q, to_d;
    logic [7:0]                      pre_q;
    logic [PWM_BITS-1:0]             cnt_q;
    logic                            err_q;
    logic                            armed_q;
    logic                            nak_set, rx_take, rx_avail;
    logic                            step, wrap;

    logic [7:0] rx_byte;
    logic [3:0] dig_val, hex_val;
    logic [7:0] hh, mask8;
    logic       is_dig, is_hex;
    logic       unused_do_bits;

    assign rx_byte        = reg_dat_do[7:0];
    assign unused_do_bits = ^reg_dat_do[31:9];

    always_comb begin
        dig_val = 4'(rx_byte - 8'h30);
        is_dig  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        is_hex  = 1'b1;
        hex_val = 4'h0;
        if (is_dig)
            hex_val = dig_val;
        else if ((rx_byte >= 8'h41) && (rx_byte <= 8'h46))
            hex_val = 4'(rx_byte - 8'h37);
        else if ((rx_byte >= 8'h61) && (rx_byte <= 8'h66))
            hex_val = 4'(rx_byte - 8'h57);
        else
            is_hex = 1'b0;
        hh    = {hi_q, hex_val};
        mask8 = {4'h0, dig_val};
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        ch_d     = ch_q;
        hi_d     = hi_q;
        reply_d  = reply_q;
        to_d     = to_q;
        nak_set  = 1'b0;
        rx_take  = 1'b0;
        // One pop per byte: the data word must read empty before the next pop.
        rx_avail = armed_q && !reg_dat_do[8];
        case (state_q)
            ST_IDLE: begin
                if (rx_avail) begin
                    rx_take = 1'b1;
                    to_d    = TO_LOAD;
                    if (is_dig) begin
                        if (9'(dig_val) < 9'(1 << N_CH)) begin
                            for (int i = 0; i < int'(N_CH); i++)
                                shadow_d[i] = mask8[i] ? LVL_MAX : '0;
                            reply_d = ACK_CHAR;
                            state_d = ST_REPLY;
                        end else begin
                            nak_set = 1'b1;
                        end
                    end else if ((rx_byte == 8'h4C) || (rx_byte == 8'h6C)) begin
                        state_d = ST_GET_CH;
                    end else if ((rx_byte != 8'h0D) && (rx_byte != 8'h0A)) begin
                        nak_set = 1'b1;
                    end
                end
            end
            ST_GET_CH, ST_GET_HI, ST_GET_LO: begin
                if (rx_avail) begin
                    rx_take = 1'b1;
                    to_d    = TO_LOAD;
                    case (state_q)
                        ST_GET_CH: begin
                            if (is_dig && (9'(dig_val) < 9'(N_CH))) begin
                                ch_d    = CH_W'(dig_val);
                                state_d = ST_GET_HI;
                            end else begin
                                nak_set = 1'b1;
                            end
                        end
                        ST_GET_HI: begin
                            if (is_hex) begin
                                hi_d    = hex_val;
                                state_d = ST_GET_LO;
                            end else begin
                                nak_set = 1'b1;
                            end
                        end
                        default: begin
                            if (is_hex) begin
                                shadow_d[ch_q] = hh[7 -: PWM_BITS];
                                reply_d        = ACK_CHAR;
                                state_d        = ST_REPLY;
                            end else begin
                                nak_set = 1'b1;
                            end
                        end
                    endcase
                end else if (to_q == '0) begin
                    nak_set = 1'b1;
                end else begin
                    to_d = to_q - 1'b1;
                end
            end
            ST_REPLY: begin
                if (!reg_dat_wait)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (nak_set) begin
            reply_d = NAK_CHAR;
            state_d = ST_REPLY;
        end
    end

    assign step = (pre_q == 8'd0);
    assign wrap = step && (cnt_q == LVL_MAX);

    always_ff @(posedge hw_clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < int'(N_CH); i++) begin
                shadow_q[i] <= RESET_MASK[i] ? LVL_MAX : '0;
                active_q[i] <= RESET_MASK[i] ? LVL_MAX : '0;
            end
            ch_q    <= '0;
            hi_q    <= '0;
            reply_q <= '0;
            to_q    <= TO_LOAD;
            pre_q   <= PRE_LOAD;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            ch_q     <= ch_d;
            hi_q     <= hi_d;
            reply_q  <= reply_d;
            to_q     <= to_d;
            err_q    <= nak_set;
            if (rx_take)
                armed_q <= 1'b0;
            else if (reg_dat_do[8])
                armed_q <= 1'b1;
            if (step) begin
                pre_q <= PRE_LOAD;
                cnt_q <= cnt_q + 1'b1;
                // shadow_d so a write landing on the wrap step is not lost
                if (wrap)
                    active_q <= shadow_d;
            end else begin
                pre_q <= pre_q - 1'b1;
            end
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < int'(N_CH); i++)
            pwm_out[i] = (active_q[i] == LVL_MAX) || (cnt_q < active_q[i]);
    end

    assign reg_dat_re = resetn && rx_take;
    assign reg_dat_we = resetn && (state_q == ST_REPLY);
    assign reg_dat_di = reg_dat_we ? {24'h0, reply_q} : 32'h0;
    assign busy       = resetn && (state_q != ST_IDLE);
    assign err_pulse  = resetn && err_q;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
module tb_uart_led_cmd_ctrl;

    localparam int N_CH        = 3;
    localparam int PWM_BITS    = 8;
    localparam int PRESCALE    = 2;
    localparam int TIMEOUT_CYC = 300;
    localparam int MAXL        = (1 << PWM_BITS) - 1;
    localparam int PERIOD      = (MAXL + 1) * PRESCALE;
    localparam logic [N_CH-1:0] RST_MASK = 3'b010;
    localparam logic [7:0] ACK = "K";
    localparam logic [7:0] NAK = "?";

    logic            hw_clk = 1'b0;
    logic            resetn = 1'b0;
    logic            reg_dat_we, reg_dat_re;
    logic [31:0]     reg_dat_di;
    logic [31:0]     reg_dat_do = 32'hFFFF_FFFF;
    logic            reg_dat_wait = 1'b0;
    logic [N_CH-1:0] pwm_out;
    logic            busy, err_pulse;

    uart_led_cmd_ctrl #(
        .N_CH(N_CH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE),
        .TIMEOUT_CYC(TIMEOUT_CYC), .RESET_MASK(RST_MASK),
        .ACK_CHAR(ACK), .NAK_CHAR(NAK)
    ) dut (
        .hw_clk(hw_clk), .resetn(resetn),
        .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
        .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait),
        .pwm_out(pwm_out), .busy(busy), .err_pulse(err_pulse)
    );

    always #5 hw_clk = ~hw_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART environment
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int  gap_cnt    = 0;
    bit  pop_seen   = 0;
    int  err_cnt    = 0;
    int  re_cnt     = 0;
    bit  wait_force = 0;
    bit  wait_rand  = 0;

    // reference model: command text buffer, levels, period counter
    bit         m_valid = 0;
    int         m_shadow[N_CH];
    int         m_active[N_CH];
    int         m_cnt, m_k, m_idle;
    bit         m_armed, m_rep_on, m_err;
    logic [7:0] m_rep;
    logic [7:0] m_cmd[$];

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic void queue_reply(input logic [7:0] b);
        m_rep_on = 1;
        m_rep    = b;
        m_err    = (b == NAK);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_shadow[i] = RST_MASK[i] ? MAXL : 0;
            m_active[i] = m_shadow[i];
        end
        m_cnt = 0; m_k = 0; m_idle = 0;
        m_armed = 1; m_rep_on = 0; m_err = 0; m_rep = 8'h00;
        m_cmd.delete();
        m_valid = 1;
    endfunction

    function automatic void process_byte(input logic [7:0] b);
        int d, ch, lvl;
        m_idle = 0;
        if (m_cmd.size() == 0) begin
            if (b >= "0" && b <= "9") begin
                d = int'(b) - 48;
                if (d < (1 << N_CH)) begin
                    for (int i = 0; i < N_CH; i++) m_shadow[i] = ((d >> i) & 1) != 0 ? MAXL : 0;
                    queue_reply(ACK);
                end else queue_reply(NAK);
            end else if (b == "L" || b == "l") m_cmd.push_back(b);
            else if (b != 8'h0D && b != 8'h0A) queue_reply(NAK);
        end else if (m_cmd.size() == 1) begin
            if (b >= "0" && b <= "9" && (int'(b) - 48) < N_CH) m_cmd.push_back(b);
            else begin m_cmd.delete(); queue_reply(NAK); end
        end else if (hexval(b) < 0) begin
            m_cmd.delete(); queue_reply(NAK);
        end else if (m_cmd.size() == 2) begin
            m_cmd.push_back(b);
        end else begin
            ch  = int'(m_cmd[1]) - 48;
            lvl = (hexval(m_cmd[2]) * 16 + hexval(b)) >> (8 - PWM_BITS);
            m_shadow[ch] = lvl;
            m_cmd.delete();
            queue_reply(ACK);
        end
    endfunction

    function automatic void model_advance(input bit take);
        bit step;
        step = (m_k % PRESCALE) == (PRESCALE - 1);
        m_k++;
        m_err = 0;
        if (m_rep_on) begin
            if (!reg_dat_wait) m_rep_on = 0;
        end else if (take) begin
            process_byte(reg_dat_do[7:0]);
        end else if (m_cmd.size() > 0) begin
            m_idle++;
            if (m_idle >= TIMEOUT_CYC) begin m_cmd.delete(); queue_reply(NAK); end
        end
        if (take) m_armed = 0;
        else if (reg_dat_do[8]) m_armed = 1;
        if (step) begin
            if (m_cnt == MAXL) begin m_cnt = 0; m_active = m_shadow; end
            else m_cnt++;
        end
    endfunction

    always @(negedge hw_clk) begin
        logic [N_CH-1:0] e_pwm;
        logic            e_we, e_re, e_busy, e_err;
        logic [31:0]     e_di;
        if (resetn && reg_dat_we && !reg_dat_wait) tx_log.push_back(reg_dat_di[7:0]);
        if (err_pulse) err_cnt++;
        if (reg_dat_re) re_cnt++;
        pop_seen = reg_dat_re;
        e_re = 0;
        if (m_valid) begin
            for (int i = 0; i < N_CH; i++) e_pwm[i] = (m_active[i] == MAXL) || (m_cnt < m_active[i]);
            if (!resetn) begin
                e_we = 0; e_busy = 0; e_err = 0; e_di = 32'h0;
            end else begin
                e_we   = m_rep_on;
                e_di   = m_rep_on ? {24'h0, m_rep} : 32'h0;
                e_busy = m_rep_on || (m_cmd.size() > 0);
                e_err  = m_err;
                e_re   = !m_rep_on && m_armed && !reg_dat_do[8];
            end
            check("cycle_outputs",
                  64'({busy, err_pulse, reg_dat_we, reg_dat_re, reg_dat_di, pwm_out}),
                  64'({e_busy, e_err, e_we, e_re, e_di, e_pwm}));
        end
        if (!resetn) model_reset();
        else if (m_valid) model_advance(e_re);
    end

    task automatic tick();
        @(posedge hw_clk); #1;
        if (pop_seen) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            pop_seen = 0;
            gap_cnt  = $urandom_range(1, 3);
        end else if (gap_cnt > 0) gap_cnt--;
        reg_dat_do   = (rx_q.size() > 0 && gap_cnt == 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF;
        reg_dat_wait = wait_force ? 1'b1 : (wait_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int c = 0;
        while (tx_log.size() < n && c < budget) begin tick(); c++; end
        if (tx_log.size() < n) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timed out, tx count %0d expected %0d", name, tx_log.size(), n);
        end
    endtask

    function automatic logic [7:0] tx_at(input int idx);
        return (idx < tx_log.size()) ? tx_log[idx] : 8'h00;
    endfunction

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, hi0, hi1, hi2, n0, c;
        string pool;
        repeat (3) tick();
        resetn = 1;

        // quiet after reset: pwm constant at reset mask, no strobes
        bad = 0;
        for (int i = 0; i < 1000; i++) begin tick(); #1; if (pwm_out != 3'b010) bad++; end
        check("quiet_pwm_bad_cycles", bad, 0);
        check("quiet_re_count", re_cnt, 0);
        check("quiet_tx_count", tx_log.size(), 0);

        // '5' -> mask 101
        send("5");
        wait_tx(1, 100, "ack_5_wait");
        check("ack_5_byte", tx_at(0), "K");
        check("pop_5_count", re_cnt, 1);
        repeat (PERIOD + 8) tick();
        #1 check("pwm_after_5", pwm_out, 3'b101);

        // L17F -> channel 1 at 127/256
        send("L17F");
        wait_tx(2, 200, "ack_l17f_wait");
        check("ack_l17f_byte", tx_at(1), "K");
        repeat (PERIOD + 8) tick();
        hi0 = 0; hi1 = 0; hi2 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick(); #1;
            hi0 += pwm_out[0]; hi1 += pwm_out[1]; hi2 += pwm_out[2];
        end
        check("ch1_high_cycles", hi1, 127 * PRESCALE);
        check("ch0_high_cycles", hi0, PERIOD);
        check("ch2_high_cycles", hi2, PERIOD);

        // bad channel and out-of-range mask
        n0 = err_cnt;
        send("L3");
        wait_tx(3, 200, "nak_l3_wait");
        check("nak_l3_byte", tx_at(2), "?");
        repeat (3) tick();
        check("nak_l3_err_pulses", err_cnt - n0, 1);
        send("9");
        wait_tx(4, 200, "nak_9_wait");
        check("nak_9_byte", tx_at(3), "?");

        // inter-byte timeout
        send("L0");
        wait_tx(5, TIMEOUT_CYC + 200, "timeout_wait");
        check("timeout_byte", tx_at(4), "?");
        repeat (3) tick();
        #1 check("timeout_busy", busy, 1'b0);
        send("0");
        wait_tx(6, 200, "ack_0_wait");
        check("ack_0_byte", tx_at(5), "K");
        repeat (PERIOD + 8) tick();
        #1 check("pwm_after_0", pwm_out, 3'b000);

        // transmitter stalled for 50 cycles
        wait_force = 1;
        n0 = tx_log.size();
        send("7");
        c = 0;
        while (c < 200) begin tick(); #1; if (reg_dat_we) break; c++; end
        check("stall_we_seen", reg_dat_we, 1'b1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(); #1;
            if (!reg_dat_we || reg_dat_di != 32'h4B) bad++;
        end
        check("stall_we_di_stable", bad, 0);
        wait_force = 0;
        repeat (20) tick();
        check("stall_single_write", tx_log.size(), n0 + 1);
        check("stall_write_byte", tx_at(n0), "K");

        // reset in the middle of "L2A"
        send("L2A");
        c = 0;
        while (rx_q.size() > 1 && c < 200) begin tick(); c++; end
        resetn = 0;
        rx_q.delete();
        gap_cnt = 0;
        tick(); tick(); #1;
        check("reset_pwm", pwm_out, RST_MASK);
        check("reset_strobes", {busy, err_pulse, reg_dat_we, reg_dat_re}, 4'b0000);
        check("reset_di", reg_dat_di, 32'h0);
        resetn = 1;
        n0 = tx_log.size();
        repeat (100) tick();
        check("reset_no_reply", tx_log.size(), n0);

        // random traffic against the model
        pool = "0123456789LLLlll0123ABCDEFabcdefgZ\r\n#";
        wait_rand = 1;
        for (int i = 0; i < 400; i++) begin
            int k = $urandom_range(0, pool.len() - 1);
            rx_q.push_back(pool[k]);
        end
        c = 0;
        while (rx_q.size() > 0 && c < 20000) begin tick(); c++; end
        check("random_rx_drained", rx_q.size(), 0);
        wait_rand = 0;
        c = 0;
        while (c < TIMEOUT_CYC + 100) begin tick(); #1; if (!busy) break; c++; end
        repeat (TIMEOUT_CYC + 50) tick();
        #1 check("random_final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
